// File: rtl/alu_issue_ctrl_if.sv
// Decode-to-ALU-to-writeback signal bundle for alu_issue_ctrl.
// The master view belongs to the controller, and the slave view belongs to the surrounding pipeline.
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [0:5]  in_aluType;
    logic [0:63] in_oprA;
    logic [0:63] in_oprB;
    logic [0:1]  in_ww;
    logic [0:4]  in_imm;
    logic [0:4]  in_rd;
    logic        aluEN;
    logic [0:5]  aluType;
    logic [0:63] oprA;
    logic [0:63] oprB;
    logic [0:1]  ww;
    logic [0:4]  imm;
    logic [0:63] alu_dout;
    logic        wb_valid;
    logic        wb_ready;
    logic [0:63] wb_data;
    logic [0:4]  wb_rd;

    modport master (
        input  in_valid, in_aluType, in_oprA, in_oprB, in_ww, in_imm, in_rd,
        input  alu_dout, wb_ready,
        output in_ready, aluEN, aluType, oprA, oprB, ww, imm,
        output wb_valid, wb_data, wb_rd
    );

    modport slave (
        output in_valid, in_aluType, in_oprA, in_oprB, in_ww, in_imm, in_rd,
        output alu_dout, wb_ready,
        input  in_ready, aluEN, aluType, oprA, oprB, ww, imm,
        input  wb_valid, wb_data, wb_rd
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue sequencer: accept one op, hold operands for 1 or MULT_LAT cycles, hand the result to writeback.
// Optional counters: define ALU_ISSUE_STATS_EN to add the stat_single, stat_mult and stat_stall outputs.
module alu_issue_ctrl #(
    parameter int MULT_LAT = 4
) (
    input  logic clk,
    input  logic reset_n,
    alu_issue_ctrl_if.master bus
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [0:31] stat_single,
    output logic [0:31] stat_mult,
    output logic [0:31] stat_stall
`endif
);
    localparam logic [3:0] CNT_MULT = 4'(MULT_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, WB} stateT;

    stateT      stateReg, stateNext;
    logic [3:0] cntReg;
    logic       readyInt;
    logic       accept;
    logic       isMult;

    assign isMult = (((bus.in_aluType == 6'b000101) || (bus.in_aluType == 6'b000110)) && (bus.in_ww == 2'b11))
                 || (bus.in_aluType == 6'b000111) || (bus.in_aluType == 6'b001000);

    // Ready comes from the state and wb_ready only, so it never loops back through in_valid.
    assign readyInt = (stateReg == IDLE) || ((stateReg == WB) && bus.wb_ready);
    assign accept   = readyInt && bus.in_valid;

    always_comb begin
        stateNext    = stateReg;
        bus.in_ready = readyInt;
        bus.aluEN    = 1'b0;
        bus.wb_valid = 1'b0;
        case (stateReg)
            IDLE: begin
                if (accept) stateNext = EXEC;
            end
            EXEC: begin
                bus.aluEN = 1'b1;
                if (cntReg == 4'd0) stateNext = WB;
            end
            WB: begin
                bus.wb_valid = 1'b1;
                if (bus.wb_ready) stateNext = bus.in_valid ? EXEC : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg    <= IDLE;
            cntReg      <= 4'd0;
            bus.aluType <= '0;
            bus.oprA    <= '0;
            bus.oprB    <= '0;
            bus.ww      <= '0;
            bus.imm     <= '0;
            bus.wb_data <= '0;
            bus.wb_rd   <= '0;
        end else begin
            stateReg <= stateNext;
            // Accept only happens in IDLE or WB, so it never collides with the EXEC countdown.
            if (accept) begin
                bus.aluType <= bus.in_aluType;
                bus.oprA    <= bus.in_oprA;
                bus.oprB    <= bus.in_oprB;
                bus.ww      <= bus.in_ww;
                bus.imm     <= bus.in_imm;
                bus.wb_rd   <= bus.in_rd;
                cntReg      <= isMult ? CNT_MULT : 4'd0;
            end else if (stateReg == EXEC) begin
                if (cntReg != 4'd0) cntReg <= cntReg - 4'd1;
                else                bus.wb_data <= bus.alu_dout;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [2:0] statInc;

    assign statInc[0] = accept && !isMult;
    assign statInc[1] = accept && isMult;
    assign statInc[2] = (stateReg == WB) && !bus.wb_ready;

    for (genvar gi = 0; gi < 3; gi++) begin : gStat
        logic [0:31] cntStat;
        // Counters saturate at all-ones instead of wrapping.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)                          cntStat <= '0;
            else if (statInc[gi] && cntStat != '1) cntStat <= cntStat + 32'd1;
        end
    end

    assign stat_single = gStat[0].cntStat;
    assign stat_mult   = gStat[1].cntStat;
    assign stat_stall  = gStat[2].cntStat;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with MULT_LAT=4 and a small combinational ALU model.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   nVec = 0;
    int   nErr = 0;

    alu_issue_ctrl_if bus ();

`ifdef ALU_ISSUE_STATS_EN
    logic [0:31] stat_single, stat_mult, stat_stall;
    alu_issue_ctrl #(.MULT_LAT(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .stat_single(stat_single), .stat_mult(stat_mult), .stat_stall(stat_stall)
    );
`else
    alu_issue_ctrl #(.MULT_LAT(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    // ALU model: add for type 1, multiply for type 7, subtract for type 5, xor otherwise.
    assign bus.alu_dout = (bus.aluType == 6'd1) ? bus.oprA + bus.oprB :
                          (bus.aluType == 6'd7) ? bus.oprA * bus.oprB :
                          (bus.aluType == 6'd5) ? bus.oprA - bus.oprB :
                                                  bus.oprA ^ bus.oprB;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setOp(input logic [5:0] t, input logic [1:0] w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        bus.in_aluType = t;
        bus.in_ww      = w;
        bus.in_oprA    = a;
        bus.in_oprB    = b;
        bus.in_rd      = rd;
        bus.in_imm     = 5'(rd + 5'd1);
    endtask

    // Issue from IDLE, count cycles to wb_valid, check what is held during EXEC and WB, then drain.
    task automatic runOp(input string tag, input logic [5:0] t, input logic [1:0] w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input int expLat, input logic [63:0] expData);
        int lat;
        checkVal({tag, ".idleRdy"}, 64'(bus.in_ready), 64'd1);
        setOp(t, w, a, b, rd);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_oprA  = '1;
        bus.in_ww    = ~w;
        lat = 0;
        while (!bus.wb_valid && lat < 30) begin
            checkVal({tag, ".en"},   64'(bus.aluEN), 64'd1);
            checkVal({tag, ".oprA"}, bus.oprA, a);
            checkVal({tag, ".oprB"}, bus.oprB, b);
            checkVal({tag, ".ww"},   64'(bus.ww), 64'(w));
            checkVal({tag, ".rdy"},  64'(bus.in_ready), 64'd0);
            tick();
            lat++;
        end
        checkVal({tag, ".lat"},   64'(lat), 64'(expLat));
        checkVal({tag, ".data"},  bus.wb_data, expData);
        checkVal({tag, ".rd"},    64'(bus.wb_rd), 64'(rd));
        checkVal({tag, ".type"},  64'(bus.aluType), 64'(t));
        checkVal({tag, ".imm"},   64'(bus.imm), 64'(5'(rd + 5'd1)));
        checkVal({tag, ".wbEn"},  64'(bus.aluEN), 64'd0);
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        checkVal({tag, ".drain"}, 64'(bus.wb_valid), 64'd0);
    endtask

    initial begin
        int acc;
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b0;
        setOp(6'd0, 2'd0, 64'd0, 64'd0, 5'd0);

        // Reset state
        repeat (3) tick();
        checkVal("rst.en",   64'(bus.aluEN), 64'd0);
        checkVal("rst.wbv",  64'(bus.wb_valid), 64'd0);
        checkVal("rst.oprA", bus.oprA, 64'd0);
        checkVal("rst.data", bus.wb_data, 64'd0);
        reset_n = 1'b1;
        checkVal("rst.rdy",  64'(bus.in_ready), 64'd1);

        // Single-cycle and multicycle ops
        runOp("t1.add",    6'b000001, 2'b00, 64'd5,  64'd3,  5'd7,  1, 64'd8);
        runOp("t2.mul",    6'b000111, 2'b00, 64'd6,  64'd7,  5'd12, 4, 64'd42);
        runOp("t3.sub10",  6'b000101, 2'b10, 64'd50, 64'd8,  5'd2,  1, 64'd42);
        runOp("t3.sub11",  6'b000101, 2'b11, 64'd50, 64'd8,  5'd4,  4, 64'd42);
        runOp("t3.t8",     6'b001000, 2'b00, 64'd3,  64'd5,  5'd31, 4, 64'd6);
        runOp("t3.t6w11",  6'b000110, 2'b11, 64'd12, 64'd10, 5'd1,  4, 64'd6);
        runOp("t3.t6w01",  6'b000110, 2'b01, 64'd12, 64'd10, 5'd17, 1, 64'd6);

        // Writeback backpressure with a waiting op, then direct WB->EXEC accept
        setOp(6'b000001, 2'b00, 64'd10, 64'd20, 5'd3);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checkVal("t4.wbv", 64'(bus.wb_valid), 64'd1);
        setOp(6'b000001, 2'b00, 64'd100, 64'd1, 5'd9);
        bus.in_valid = 1'b1;
        #1;
        checkVal("t4.rdyLo", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkVal("t4.holdV",  64'(bus.wb_valid), 64'd1);
            checkVal("t4.holdD",  bus.wb_data, 64'd30);
            checkVal("t4.holdRd", 64'(bus.wb_rd), 64'd3);
            checkVal("t4.noAcc",  bus.oprA, 64'd10);
        end
        bus.wb_ready = 1'b1;
        #1;
        checkVal("t4.rdyHi", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        checkVal("t4.exec",  64'(bus.aluEN), 64'd1);
        checkVal("t4.oprA",  bus.oprA, 64'd100);
        checkVal("t4.wbvLo", 64'(bus.wb_valid), 64'd0);
        tick();
        checkVal("t4.wbv2",  64'(bus.wb_valid), 64'd1);
        checkVal("t4.data2", bus.wb_data, 64'd101);
        checkVal("t4.rd2",   64'(bus.wb_rd), 64'd9);
        tick();
        checkVal("t4.idle",  64'(bus.wb_valid), 64'd0);
        bus.wb_ready = 1'b0;

        // Back-to-back single-cycle ops with wb_ready high: one accept every 2 cycles
        setOp(6'b000001, 2'b00, 64'd1, 64'd1, 5'd5);
        bus.in_valid = 1'b1;
        bus.wb_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        checkVal("b2b.acc", 64'(acc), 64'd3);
        tick();
        bus.wb_ready = 1'b0;
        checkVal("b2b.idle", 64'(bus.wb_valid), 64'd0);

`ifdef ALU_ISSUE_STATS_EN
        checkVal("st.single", 64'(stat_single), 64'd8);
        checkVal("st.mult",   64'(stat_mult),   64'd4);
        checkVal("st.stall",  64'(stat_stall),  64'd5);
`endif

        // Reset in the 2nd EXEC cycle of a multicycle op
        setOp(6'b000111, 2'b00, 64'd2, 64'd3, 5'd6);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        checkVal("t5.en2", 64'(bus.aluEN), 64'd1);
        reset_n = 1'b0;
        #1;
        checkVal("t5.en",   64'(bus.aluEN), 64'd0);
        checkVal("t5.wbv",  64'(bus.wb_valid), 64'd0);
        checkVal("t5.oprA", bus.oprA, 64'd0);
        checkVal("t5.type", 64'(bus.aluType), 64'd0);
        checkVal("t5.rd",   64'(bus.wb_rd), 64'd0);
`ifdef ALU_ISSUE_STATS_EN
        checkVal("t5.stClr", 64'(stat_single) + 64'(stat_mult) + 64'(stat_stall), 64'd0);
`endif
        repeat (2) tick();
        reset_n = 1'b1;
        checkVal("t5.rdy", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkVal("t5.noWb", 64'(bus.wb_valid), 64'd0);
            checkVal("t5.noEn", 64'(bus.aluEN), 64'd0);
        end
        checkVal("t5.data", bus.wb_data, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue-side sequencer that drives the ALU operand/control interface (aluEN, aluType, oprA, oprB, ww, imm) and collects its 64-bit result. It accepts one decoded ALU operation at a time from the decode stage over a valid/ready handshake. It holds the operands stable for one cycle (single-cycle ops) or MULT_LAT cycles (multicycle ops), captures the ALU result, and presents it to writeback over a second valid/ready handshake.

Parameters:
MULT_LAT, 4, cycles the operands are held for a multicycle op before the result is captured; legal range 2..15.

Ports:
clk  in  1  clock, all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  decode has an op
in_ready  out  1  controller accepts the op this cycle
in_aluType  in  [0:5]  op type
in_oprA  in  [0:63]  operand A
in_oprB  in  [0:63]  operand B
in_ww  in  [0:1]  element width
in_imm  in  [0:4]  immediate
in_rd  in  [0:4]  destination register tag
aluEN  out  1  ALU enable
aluType  out  [0:5]  registered op type to ALU
oprA  out  [0:63]  registered operand A
oprB  out  [0:63]  registered operand B
ww  out  [0:1]  registered width
imm  out  [0:4]  registered immediate
alu_dout  in  [0:63]  ALU result (combinational from ALU)
wb_valid  out  1  result available
wb_ready  in  1  writeback accepts the result
wb_data  out  [0:63]  captured result
wb_rd  out  [0:4]  destination tag of the result

Behaviour:
- Multicycle classification is applied to in_* at accept: mc = ((type==000101 or 000110) and ww==11) or type==000111 or type==001000.
- States:
  - IDLE: in_ready=1. On the accept edge, latch all in_* into the output regs and wb_rd, and go to EXEC. Set cnt = mc ? MULT_LAT-1 : 0.
  - EXEC: aluEN=1, operands held constant, in_ready=0.
    - cnt!=0: decrement cnt.
    - cnt==0: capture alu_dout into wb_data, go to WB.
  - WB: wb_valid=1, aluEN=0, wb_data and wb_rd held.
    - in_ready = wb_ready.
    - If wb_ready and in_valid: accept the new op directly and go to EXEC.
    - If wb_ready and no new op: go to IDLE.
- Latency from the accept edge k:
  - single-cycle op: result captured at edge k+1, wb_valid high from k+1;
  - multicycle op: result captured at edge k+MULT_LAT.
- Back-to-back ops with wb_ready held high: one op per 2 cycles (single-cycle) or per MULT_LAT+1 cycles (multicycle).
- wb_valid must not drop until wb_ready is sampled high.
- in_ready never depends combinationally on in_valid.
- Operand/control outputs change only on an accept edge. Between ops they retain their last values; only aluEN gates their use.
- Reset (asynchronous, any state, including mid-EXEC):
  - state goes to IDLE and cnt to 0;
  - aluEN=0, wb_valid=0;
  - aluType, oprA, oprB, ww, imm, wb_data, wb_rd all cleared to 0;
  - the in-flight op is discarded with no writeback.
- After reset release, in_ready=1 in the first cycle.

Optional Feature:
Macro ALU_ISSUE_STATS_EN.
- Defined: adds outputs stat_single [0:31], stat_mult [0:31] and stat_stall [0:31], all reset to 0 and saturating at all-ones.
  - stat_single increments on accept of a single-cycle op.
  - stat_mult increments on accept of a multicycle op.
  - stat_stall increments every cycle with wb_valid=1 and wb_ready=0.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then accept type 000001, ww=00, oprA=5, oprB=3, with the ALU model returning 8 -> aluEN high for 1 cycle; wb_valid one cycle after accept with wb_data=8 and wb_rd equal to in_rd.
2. Multicycle type 000111, MULT_LAT=4 -> aluEN high and operands stable for 4 cycles; in_ready=0 throughout; wb_valid rises 4 cycles after accept.
3. Type 000101 with ww=10 versus ww=11 -> result after 1 cycle versus after MULT_LAT cycles respectively.
4. wb_ready held low for 5 cycles with in_valid high -> wb_valid, wb_data and wb_rd held; no accept occurs; when wb_ready rises, the new op is accepted on the same edge and goes straight to EXEC.
5. Assert reset_n low in the 2nd EXEC cycle of a multicycle op -> aluEN=0 and wb_valid=0 immediately; no result after release; in_ready=1 in the first cycle after release.
6. With ALU_ISSUE_STATS_EN: 3 single ops, 2 multicycle ops and 4 stall cycles -> stat_single=3, stat_mult=2, stat_stall=4.
